seg_ctrl: RTL and testbench

SEG_CTRL -- requirements
Module: seg_ctrl

---
 rtl/seg_ctrl.sv | 69 ++++++
 tb/tb_seg_ctrl.sv | 128 ++++++++++++
 2 files changed

// File: rtl/seg_ctrl.sv
// seg_ctrl: pipeline segment stall/flush control around a single-outstanding data bus FSM.
// Optional watchdog: define SEG_CTRL_WATCHDOG_EN to enable the timeout counter and sticky bus_err.
module seg_ctrl (
  input  logic clk,
  input  logic reset,
  input  logic ex_valid,
  input  logic ex_data_req,
  input  logic md_busy,
  input  logic ec_exc,
  input  logic data_addr_ok,
  input  logic data_data_ok,
  output logic data_req,
  output logic ec_stall,
  output logic up_stall,
  output logic ec_refresh,
  output logic ex_refresh,
  output logic rdata_valid,
  output logic bus_err
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;
  state_t r_state, w_next;
  logic r_kill;
  logic w_timeout;
  always_comb begin
    data_req    = (r_state == ADDR) || (r_state == IDLE && ex_valid && ex_data_req && !ec_exc);
    rdata_valid = r_state == DATA && data_data_ok && !ec_exc;
    ec_stall    = md_busy || r_state == ADDR || r_state == DRAIN || (r_state == DATA && !data_data_ok);
    up_stall    = ec_stall;
    ec_refresh  = ec_exc;
    ex_refresh  = ec_exc;
    w_next      = r_state;
    case (r_state)
      IDLE:    w_next = data_req ? (data_addr_ok ? DATA : ADDR) : IDLE;
      ADDR:    w_next = data_addr_ok ? ((r_kill || ec_exc) ? DRAIN : DATA) : ADDR;
      DATA:    w_next = data_data_ok ? IDLE : (ec_exc ? DRAIN : DATA);
      DRAIN:   w_next = data_data_ok ? IDLE : DRAIN;
      default: w_next = IDLE;
    endcase
  end
`ifdef SEG_CTRL_WATCHDOG_EN
  logic [7:0] r_wd_cnt;
  logic       r_bus_err;
  // the 255th busy cycle is the one leaving the counter at 254
  assign w_timeout = r_state != IDLE && r_wd_cnt == 8'd254;
  assign bus_err   = r_bus_err;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wd_cnt  <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_wd_cnt  <= (r_state == IDLE || w_timeout) ? 8'd0 : r_wd_cnt + 8'd1;
      r_bus_err <= r_bus_err || w_timeout;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign bus_err   = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_kill  <= 1'b0;
    end else begin
      r_state <= w_timeout ? IDLE : w_next;
      r_kill  <= (w_timeout || w_next == IDLE || w_next == DATA) ? 1'b0 :
                 (r_state == ADDR && ec_exc) ? 1'b1 : r_kill;
    end
  end
endmodule

// File: tb/tb_seg_ctrl.sv
// tb_seg_ctrl: directed vector table plus random stimulus against a transaction-level model.
module tb_seg_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic ex_valid = 0, ex_data_req = 0, md_busy = 0, ec_exc = 0, data_addr_ok = 0, data_data_ok = 0;
  logic data_req, ec_stall, up_stall, ec_refresh, ex_refresh, rdata_valid, bus_err;
  always #5 clk = ~clk;

  seg_ctrl dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_data_req(ex_data_req), .md_busy(md_busy),
    .ec_exc(ec_exc), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_req(data_req),
    .ec_stall(ec_stall), .up_stall(up_stall), .ec_refresh(ec_refresh), .ex_refresh(ex_refresh),
    .rdata_valid(rdata_valid), .bus_err(bus_err)
  );

  int n_vec = 0, n_bad = 0;
  bit m_out, m_adone, m_kill, m_bus;
  int m_cnt;

  typedef struct {logic [5:0] in; logic [3:0] exp;} vec_t;
  vec_t tv[$];

  task automatic check(string name, logic [6:0] exp);
    logic [6:0] got;
    got = {data_req, ec_stall, rdata_valid, ec_refresh, up_stall, ex_refresh, bus_err};
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b {req,stall,rvalid,ecref,upstall,exref,buserr}", name, got, exp);
    end
  endtask

  task automatic drive(logic [5:0] v);
    {ex_valid, ex_data_req, md_busy, ec_exc, data_addr_ok, data_data_ok} = v;
  endtask

  task automatic model_reset();
    m_out = 0; m_adone = 0; m_kill = 0; m_bus = 0; m_cnt = 0;
  endtask

  // outstanding/accepted/killed flags describe the transaction, not a state encoding
  function automatic logic [6:0] model_exp();
    logic req, stall, rv;
    req   = m_out ? !m_adone : (ex_valid && ex_data_req && !ec_exc);
    rv    = m_out && m_adone && !m_kill && data_data_ok && !ec_exc;
    stall = md_busy || (m_out && (!m_adone || m_kill || !data_data_ok));
    return {req, stall, rv, ec_exc, stall, ec_exc, m_bus};
  endfunction

  task automatic model_update();
    bit was_out, req;
    was_out = m_out;
    req = ex_valid && ex_data_req && !ec_exc;
    if (!m_out) begin
      if (req) begin m_out = 1; m_adone = data_addr_ok; m_kill = 0; end
    end else if (!m_adone) begin
      if (ec_exc) m_kill = 1;
      if (data_addr_ok) m_adone = 1;
    end else if (data_data_ok) m_out = 0;
    else if (ec_exc) m_kill = 1;
`ifdef SEG_CTRL_WATCHDOG_EN
    if (was_out) begin
      m_cnt++;
      if (m_cnt == 255) begin m_bus = 1; m_out = 0; m_cnt = 0; end
    end else m_cnt = 0;
`endif
    if (!m_out) begin m_adone = 0; m_kill = 0; end
  endtask

  task automatic step(string name, logic [5:0] v);
    @(negedge clk);
    drive(v);
    #1 check(name, model_exp());
    @(posedge clk);
    model_update();
  endtask

  initial begin
    tv = '{
      '{6'b110010, 4'b1000}, '{6'b000000, 4'b0100}, '{6'b000000, 4'b0100}, '{6'b000000, 4'b0100},
      '{6'b000001, 4'b0010},
      '{6'b110000, 4'b1000}, '{6'b000000, 4'b1100}, '{6'b000010, 4'b1100}, '{6'b000001, 4'b0010},
      '{6'b110010, 4'b1000}, '{6'b000100, 4'b0101}, '{6'b000000, 4'b0100}, '{6'b000001, 4'b0100},
      '{6'b110010, 4'b1000}, '{6'b000101, 4'b0001}, '{6'b000000, 4'b0000},
      '{6'b110000, 4'b1000}, '{6'b000100, 4'b1101}, '{6'b000010, 4'b1100}, '{6'b000000, 4'b0100},
      '{6'b000001, 4'b0100}, '{6'b000001, 4'b0000},
      '{6'b110110, 4'b0001}, '{6'b000000, 4'b0000},
      '{6'b001000, 4'b0100}, '{6'b001000, 4'b0100}, '{6'b001000, 4'b0100}, '{6'b001000, 4'b0100},
      '{6'b001000, 4'b0100}, '{6'b000000, 4'b0000},
      '{6'b110000, 4'b1000}, '{6'b000001, 4'b1100}, '{6'b000010, 4'b1100}, '{6'b000001, 4'b0010}
    };
    model_reset();
    #2 check("reset_state", 7'b0);
    @(negedge clk) reset = 1'b0;
    foreach (tv[i]) begin
      @(negedge clk);
      drive(tv[i].in);
      #1 check($sformatf("tv%0d", i), {tv[i].exp, tv[i].exp[2], tv[i].exp[0], 1'b0});
      @(posedge clk);
      model_update();
    end
    step("enter_addr", 6'b110000);
    drive(6'b0);
    #3 reset = 1'b1;
    #1 check("async_reset_mid_access", 7'b0);
    model_reset();
    @(negedge clk) reset = 1'b0;
    step("after_reset_idle", 6'b000001);
    repeat (3000)
      step("random", {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                      1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0)});
`ifdef SEG_CTRL_WATCHDOG_EN
    @(negedge clk) reset = 1'b1;
    drive(6'b0);
    model_reset();
    @(negedge clk) reset = 1'b0;
    step("wd_start", 6'b110010);
    repeat (255) step("wd_wait", 6'b0);
    #1 check("wd_timeout", 7'b0000001);
    repeat (5) step("wd_sticky", 6'b0);
    @(negedge clk) reset = 1'b1;
    #1 check("wd_cleared_by_reset", 7'b0);
    model_reset();
    @(negedge clk) reset = 1'b0;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
